// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// ----------------
// Multiplexed common-anode 7-segment driver. A binary value is captured on
// `load` and turned into BCD by a sequential shift-add-3 engine. The result
// is then scanned across DIGITS digits. Scan timing comes from clock enables
// derived from clk; no divided clocks are used.
//
// Features: leading-zero blanking, a per-digit blink mask, and an overflow
// indication that shows dashes on every digit.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   value       binary value to display (BIN_W bits)
//   load        single-cycle strobe that samples value
//   blank_lz    1 = blank leading zeros (digit 0 is never blanked)
//   blink_en    1 = masked digits blink
//   blink_mask  bit i = digit i blinks
//   seg         active-low segments, seg[0]=a .. seg[6]=g (registered)
//   an          active-low anodes, an[0] = rightmost digit (registered)
//   busy        conversion in progress
//   ovf         last committed value exceeded 10^DIGITS-1
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int BIN_W     = 14,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    input  logic              blank_lz,
    input  logic              blink_en,
    input  logic [DIGITS-1:0] blink_mask,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy,
    output logic              ovf
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ITER_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t              state_reg;
    logic [BIN_W-1:0]    shift_reg;
    logic [BCD_W-1:0]    bcd_reg;
    logic [BCD_W-1:0]    bcd_adj;
    logic [ITER_W-1:0]   iter_reg;
    logic                ovf_cap_reg;
    logic [BCD_W-1:0]    disp_reg;
    logic                ovf_reg;
    logic [BIN_W-1:0]    pend_val_reg;
    logic                pend_reg;
    logic                busy_reg;

    logic [BIN_W-1:0]    cap_val;
    logic                cap_ovf;

    // A fresh load in COMMIT is newer than anything pending, so it wins.
    assign cap_val = load ? value : pend_val_reg;
    assign cap_ovf = (64'(cap_val) > MAX_VAL);

    // Add-3 correction of every nibble that is 5 or more, before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            ovf_cap_reg  <= 1'b0;
            disp_reg     <= '0;
            ovf_reg      <= 1'b0;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        shift_reg   <= cap_val;
                        bcd_reg     <= '0;
                        iter_reg    <= '0;
                        ovf_cap_reg <= cap_ovf;
                        busy_reg    <= 1'b1;
                        state_reg   <= CONV;
                    end
                end
                CONV: begin
                    // BCD accumulator and binary shifter move as one register.
                    {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    if (iter_reg == ITER_W'(BIN_W - 1)) begin
                        state_reg <= COMMIT;
                    end else begin
                        iter_reg <= iter_reg + 1'b1;
                    end
                    if (load) begin
                        pend_val_reg <= value;
                        pend_reg     <= 1'b1;
                    end
                end
                COMMIT: begin
                    disp_reg <= bcd_reg;
                    ovf_reg  <= ovf_cap_reg;
                    if (load || pend_reg) begin
                        // Chain straight into the next conversion, no IDLE gap.
                        shift_reg   <= cap_val;
                        bcd_reg     <= '0;
                        iter_reg    <= '0;
                        ovf_cap_reg <= cap_ovf;
                        pend_reg    <= 1'b0;
                        state_reg   <= CONV;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign ovf  = ovf_reg;

    // ------------------------------------------------------------------
    // Scan, blink and segment output
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]   presc_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [BCD_W-1:0]    shown_reg;
    logic                shown_ovf_reg;
    logic [BLINK_W-1:0]  blink_cnt_reg;
    logic                blink_flag_reg;
    logic [6:0]          seg_reg;
    logic [DIGITS-1:0]   an_reg;

    logic [3:0]          digit_arr [DIGITS];
    logic [DIGITS-1:0]   lz_blank;
    logic [6:0]          seg_next;
    logic                slot_wrap;

    assign slot_wrap = (presc_reg == SCAN_W'(SCAN_DIV - 1));

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = shown_reg[4*gi +: 4];
            // Digit gi and everything above it are zero.
            assign lz_blank[gi]  = (shown_reg[BCD_W-1 : 4*gi] == '0);
        end
    endgenerate

    always_comb begin
        seg_next = decode(digit_arr[idx_reg]);
        if (shown_ovf_reg) begin
            seg_next = SEG_DASH;
        end else if (blank_lz && (idx_reg != '0) && lz_blank[idx_reg]) begin
            seg_next = SEG_BLANK;
        end
        if (blink_en && !blink_flag_reg && blink_mask[idx_reg]) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg     <= '0;
            idx_reg       <= '0;
            shown_reg     <= '0;
            shown_ovf_reg <= 1'b0;
            seg_reg       <= SEG_BLANK;
            an_reg        <= '1;
        end else begin
            if (slot_wrap) begin
                presc_reg <= '0;
                idx_reg   <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                // New content is only picked up at slot boundaries so a digit
                // never changes in the middle of its lit period. A commit on
                // this same edge is taken directly from the converter.
                shown_reg     <= (state_reg == COMMIT) ? bcd_reg     : disp_reg;
                shown_ovf_reg <= (state_reg == COMMIT) ? ovf_cap_reg : ovf_reg;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            an_reg  <= ~(DIGITS'(1) << idx_reg);
            seg_reg <= seg_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_reg  <= '0;
            blink_flag_reg <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt_reg  <= '0;
            blink_flag_reg <= 1'b1;
        end else if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_reg  <= '0;
            blink_flag_reg <= ~blink_flag_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with DIGITS=4, BIN_W=14, SCAN_DIV=4,
// BLINK_DIV=8. Expected (an, seg) pairs are queued when stimulus is applied
// and popped when the matching scan cycle is observed.
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int BIN_W     = 14;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [BIN_W-1:0]  value = '0;
    logic              load = 1'b0;
    logic              blank_lz = 1'b0;
    logic              blink_en = 1'b0;
    logic [DIGITS-1:0] blink_mask = '0;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              busy;
    logic              ovf;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_q [$];

    // Standard active-low patterns, index = digit value; index 10 = dash, 11 = blank.
    logic [6:0] pat [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                             7'h3F, 7'h7F};

    seg7_scan_driver #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
        .seg(seg), .an(an), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic do_load(input int v);
        @(negedge clk);
        value = BIN_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Returns at the first sample of a digit-0 slot.
    task automatic sync_digit0(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = an;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) begin
                ok = 1'b1;
                return;
            end
            prev = an;
        end
    endtask

    // Queue one full scan frame; s[d] is the expected pattern on digit d.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int t = 0; t < DIGITS * SCAN_DIV; t++) begin
            exp_q.push_back({an_of(t / SCAN_DIV), s[t / SCAN_DIV]});
        end
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
        n_tests++;
        if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
        n_tests++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got busy=%b ovf=%b want 0 0", busy, ovf);
        end
        rst = 1'b1;
        for (int t = 0; t < 2 * SCAN_DIV; t++) begin
            exp_q.push_back({an_of(t / SCAN_DIV), pat[0]});
        end
        for (int t = 0; t < 2 * SCAN_DIV; t++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL reset_scan t=%0d got an=%b seg=%h want an=%b seg=%h", t, an, seg, e[10:7], e[6:0]);
            end
        end
    endtask

    task automatic test_convert();
        int n;
        bit ok;
        logic [10:0] e;
        blank_lz = 1'b0;
        do_load(1234);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (n != BIN_W + 1) begin n_fail++; $display("FAIL conv_busy_cycles got %0d want %0d", n, BIN_W + 1); end
        n_tests++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL conv_ovf got %b want 0", ovf); end
        push_frame(pat[4], pat[3], pat[2], pat[1]);
        sync_digit0(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL conv_sync got timeout want digit0 slot"); exp_q.delete(); end
        for (int t = 0; ok && t < DIGITS * SCAN_DIV; t++) begin
            if (t > 0) @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL conv_scan t=%0d got an=%b seg=%h want an=%b seg=%h", t, an, seg, e[10:7], e[6:0]);
            end
        end
    endtask

    task automatic test_blank();
        int vals [3] = '{7, 0, 305};
        logic [6:0] f [3][4];
        bit ok;
        logic [10:0] e;
        f[0] = '{pat[7], pat[11], pat[11], pat[11]};
        f[1] = '{pat[0], pat[11], pat[11], pat[11]};
        f[2] = '{pat[5], pat[0],  pat[3],  pat[11]};
        blank_lz = 1'b1;
        for (int c = 0; c < 3; c++) begin
            do_load(vals[c]);
            wait_idle(ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL blank_idle v=%0d got busy stuck want idle", vals[c]); end
            push_frame(f[c][0], f[c][1], f[c][2], f[c][3]);
            sync_digit0(ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL blank_sync got timeout want digit0 slot"); exp_q.delete(); end
            for (int t = 0; ok && t < DIGITS * SCAN_DIV; t++) begin
                if (t > 0) @(negedge clk);
                e = exp_q.pop_front();
                n_tests++;
                if ({an, seg} !== e) begin
                    n_fail++;
                    $display("FAIL blank_scan v=%0d t=%0d got an=%b seg=%h want an=%b seg=%h",
                             vals[c], t, an, seg, e[10:7], e[6:0]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int vals [2] = '{10000, 9999};
        logic [6:0] ps [2] = '{7'h3F, 7'h10};
        logic want_ovf [2] = '{1'b1, 1'b0};
        bit ok;
        logic [10:0] e;
        blank_lz = 1'b1;
        for (int c = 0; c < 2; c++) begin
            do_load(vals[c]);
            wait_idle(ok);
            n_tests++;
            if (ovf !== want_ovf[c] || !ok) begin
                n_fail++; $display("FAIL ovf_flag v=%0d got ovf=%b want %b", vals[c], ovf, want_ovf[c]);
            end
            push_frame(ps[c], ps[c], ps[c], ps[c]);
            sync_digit0(ok);
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL ovf_sync got timeout want digit0 slot"); exp_q.delete(); end
            for (int t = 0; ok && t < DIGITS * SCAN_DIV; t++) begin
                if (t > 0) @(negedge clk);
                e = exp_q.pop_front();
                n_tests++;
                if ({an, seg} !== e) begin
                    n_fail++;
                    $display("FAIL ovf_scan v=%0d t=%0d got an=%b seg=%h want an=%b seg=%h",
                             vals[c], t, an, seg, e[10:7], e[6:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, bad, c;
        bit ok;
        logic [10:0] e;
        blank_lz = 1'b1;
        do_load(5);
        n = 0; bad = 0; c = 0;
        // Busy must stay high across both conversions; 42 must never reach the display.
        while (c < 300) begin
            if (busy !== 1'b1) break;
            n++;
            if (seg == pat[2] || seg == pat[4]) bad++;
            if (c == 2) begin value = BIN_W'(42); load = 1'b1; end
            if (c == 3) load = 1'b0;
            if (c == 5) begin value = BIN_W'(99); load = 1'b1; end
            if (c == 6) load = 1'b0;
            c++;
            @(negedge clk);
        end
        n_tests++;
        if (n != 2 * (BIN_W + 1)) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want %0d", n, 2 * (BIN_W + 1)); end
        push_frame(pat[9], pat[9], pat[11], pat[11]);
        sync_digit0(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_sync got timeout want digit0 slot"); exp_q.delete(); end
        for (int t = 0; ok && t < DIGITS * SCAN_DIV; t++) begin
            if (t > 0) @(negedge clk);
            if (seg == pat[2] || seg == pat[4]) bad++;
            e = exp_q.pop_front();
            n_tests++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL b2b_scan t=%0d got an=%b seg=%h want an=%b seg=%h", t, an, seg, e[10:7], e[6:0]);
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_42_shown got %0d cycles want 0", bad); end
    endtask

    task automatic test_blink();
        bit ok, vis;
        int d;
        logic [6:0] ps [4];
        logic [6:0] s;
        logic [10:0] e;
        ps = '{pat[4], pat[3], pat[2], pat[1]};
        blank_lz   = 1'b0;
        blink_en   = 1'b0;
        blink_mask = 4'b0010;
        do_load(1234);
        wait_idle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL blink_idle got busy stuck want idle"); end
        sync_digit0(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL blink_sync got timeout want digit0 slot"); end
        // blink_en is first sampled at the edge of sample 14; the digit-1 slot
        // of the second frame then straddles the first toggle.
        for (int t = 0; ok && t < 80; t++) begin
            d = (t / SCAN_DIV) % DIGITS;
            vis = (t < 14) ? 1'b1 : ((((t - 14) / BLINK_DIV) % 2) == 0);
            s = (d == 1 && !vis) ? pat[11] : ps[d];
            exp_q.push_back({an_of(d), s});
            e = exp_q.pop_front();
            n_tests++;
            if ({an, seg} !== e) begin
                n_fail++;
                $display("FAIL blink_scan t=%0d got an=%b seg=%h want an=%b seg=%h", t, an, seg, e[10:7], e[6:0]);
            end
            if (t == 13) blink_en = 1'b1;
            @(negedge clk);
        end
        blink_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        blank_lz = 1'b0;
        do_load(5678);
        repeat (2) @(negedge clk);
        value = BIN_W'(1111);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got seg=%h an=%b busy=%b want 7f 1111 0", seg, an, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 40; t++) begin
            exp_q.push_back({an_of((t / SCAN_DIV) % DIGITS), pat[0]});
        end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if ({an, seg} !== e || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_scan t=%0d got an=%b seg=%h busy=%b want an=%b seg=%h busy=0",
                         t, an, seg, busy, e[10:7], e[6:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blank();
        test_overflow();
        test_back_to_back();
        test_blink();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
